// File: rtl/voice_allocator.sv
// PS/2 set-2 keyboard to polyphonic voice allocator: parses make/break codes,
// assigns notes to voices with LRU stealing, and tracks a global octave.
module voice_allocator #(
  parameter int VOICES   = 4,
  parameter int OCT_INIT = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            ps2_byte,
  input  logic                  ps2_valid,
  input  logic                  ps2_ovf,
  output logic [4*VOICES-1:0]   notes,
  output logic [2*VOICES-1:0]   octs,
  output logic [1:0]            octave,
  output logic [3:0]            active,
  output logic                  steal
);

  localparam logic [2:0] RMAX = 3'(VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_make;
  logic        w_break;

  logic [3:0]  w_key;
  logic        w_oct_up;
  logic        w_oct_dn;

  logic [3:0]  r_note [VOICES];
  logic [1:0]  r_oct  [VOICES];
  logic [2:0]  r_rank [VOICES];
  logic [3:0]  w_note_next [VOICES];
  logic [1:0]  w_oct_next  [VOICES];
  logic [2:0]  w_rank_next [VOICES];

  logic [1:0]  r_octave;
  logic [1:0]  w_octave_next;
  logic [3:0]  r_active;
  logic [3:0]  w_active_next;
  logic        r_steal;
  logic        w_steal_next;

  logic        w_held;
  logic        w_free;
  logic [2:0]  w_free_idx;
  logic [2:0]  w_old_idx;
  logic [2:0]  w_target;
  logic [2:0]  w_target_rank;
  logic        w_alloc;

  // Overflow wins over any strobed byte and always drops the parser back to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    if (ps2_ovf) begin
      w_state_next = ST_IDLE;
    end else if (ps2_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (ps2_byte == 8'hF0)      w_state_next = ST_BRK;
          else if (ps2_byte == 8'hE0) w_state_next = ST_EXT;
          else                        w_make       = 1'b1;
        end
        ST_BRK: begin
          w_break      = 1'b1;
          w_state_next = ST_IDLE;
        end
        ST_EXT:     w_state_next = (ps2_byte == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_key    = 4'd0;
    w_oct_up = 1'b0;
    w_oct_dn = 1'b0;
    case (ps2_byte)
      8'h1C: w_key = 4'd1;
      8'h1B: w_key = 4'd2;
      8'h23: w_key = 4'd3;
      8'h2B: w_key = 4'd4;
      8'h34: w_key = 4'd5;
      8'h33: w_key = 4'd6;
      8'h3B: w_key = 4'd7;
      8'h1A: w_oct_dn = 1'b1;
      8'h22: w_oct_up = 1'b1;
      default: w_key = 4'd0;
    endcase
  end

  // Descending scan so the lowest-index silent voice is the one that sticks.
  always_comb begin
    w_held        = 1'b0;
    w_free        = 1'b0;
    w_free_idx    = 3'd0;
    w_old_idx     = 3'd0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (r_note[i] == 4'd0) begin
        w_free     = 1'b1;
        w_free_idx = 3'(i);
      end
      if (w_key != 4'd0 && r_note[i] == w_key) w_held = 1'b1;
      if (r_rank[i] == RMAX) w_old_idx = 3'(i);
    end
    w_target = w_free ? w_free_idx : w_old_idx;
    w_alloc  = w_make && (w_key != 4'd0) && !w_held;
    w_target_rank = 3'd0;
    for (int i = 0; i < VOICES; i++) begin
      if (3'(i) == w_target) w_target_rank = r_rank[i];
    end
  end

  always_comb begin
    w_active_next = 4'd0;
    for (int i = 0; i < VOICES; i++) begin
      w_note_next[i] = r_note[i];
      w_oct_next[i]  = r_oct[i];
      w_rank_next[i] = r_rank[i];
      if (ps2_ovf) begin
        w_note_next[i] = 4'd0;
      end else if (w_alloc && w_target == 3'(i)) begin
        w_note_next[i] = w_key;
        w_oct_next[i]  = r_octave;
      end else if (w_break && w_key != 4'd0 && r_note[i] == w_key) begin
        w_note_next[i] = 4'd0;
      end
      // Moving the target to the front ages only the voices that were newer than it.
      if (w_alloc) begin
        if (w_target == 3'(i))              w_rank_next[i] = 3'd0;
        else if (r_rank[i] < w_target_rank) w_rank_next[i] = r_rank[i] + 3'd1;
      end
      w_active_next = w_active_next + 4'(w_note_next[i] != 4'd0);
    end
  end

  always_comb begin
    w_octave_next = r_octave;
    if (w_make && w_oct_up && r_octave != 2'd3) w_octave_next = r_octave + 2'd1;
    if (w_make && w_oct_dn && r_octave != 2'd0) w_octave_next = r_octave - 2'd1;
    w_steal_next = w_alloc && !w_free;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        r_note[i] <= 4'd0;
        r_oct[i]  <= 2'd0;
        r_rank[i] <= 3'(i);
      end
      r_octave <= 2'(OCT_INIT);
      r_active <= 4'd0;
      r_steal  <= 1'b0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        r_note[i] <= w_note_next[i];
        r_oct[i]  <= w_oct_next[i];
        r_rank[i] <= w_rank_next[i];
      end
      r_octave <= w_octave_next;
      r_active <= w_active_next;
      r_steal  <= w_steal_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_pack
      assign notes[4*gi +: 4] = r_note[gi];
      assign octs[2*gi +: 2]  = r_oct[gi];
    end
  endgenerate

  assign octave = r_octave;
  assign active = r_active;
  assign steal  = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios with literal expectations plus
// randomized byte streams checked every cycle against an LRU-queue model.
module tb_voice_allocator;

  localparam int V  = 4;
  localparam int OI = 1;

  logic             sys_clk;
  logic             rst_n;
  logic [7:0]       ps2_byte;
  logic             ps2_valid;
  logic             ps2_ovf;
  logic [4*V-1:0]   notes;
  logic [2*V-1:0]   octs;
  logic [1:0]       octave;
  logic [3:0]       active;
  logic             steal;

  voice_allocator #(.VOICES(V), .OCT_INIT(OI)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ps2_byte (ps2_byte),
    .ps2_valid(ps2_valid),
    .ps2_ovf  (ps2_ovf),
    .notes    (notes),
    .octs     (octs),
    .octave   (octave),
    .active   (active),
    .steal    (steal)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: voice contents plus an LRU queue of voice indices, newest first.
  int m_note [V];
  int m_oct  [V];
  int m_octave;
  bit m_steal;
  bit m_pend_brk;
  bit m_pend_ext;
  int lru [$];

  logic [4*V-1:0] e_notes;
  logic [2*V-1:0] e_octs;
  logic [3:0]     e_act;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int keymap(input logic [7:0] b);
    case (b)
      8'h1C: return 1;
      8'h1B: return 2;
      8'h23: return 3;
      8'h2B: return 4;
      8'h34: return 5;
      8'h33: return 6;
      8'h3B: return 7;
      8'h1A: return 8;
      8'h22: return 9;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    lru = {};
    for (int i = 0; i < V; i++) begin
      m_note[i] = 0;
      m_oct[i]  = 0;
      lru.push_back(i);
    end
    m_octave   = OI;
    m_steal    = 1'b0;
    m_pend_brk = 1'b0;
    m_pend_ext = 1'b0;
  endtask

  task automatic model_make(input logic [7:0] b);
    int k;
    int t;
    k = keymap(b);
    if (k == 9 && m_octave < 3) m_octave++;
    if (k == 8 && m_octave > 0) m_octave--;
    if (k >= 1 && k <= 7) begin
      for (int i = 0; i < V; i++) if (m_note[i] == k) return;
      t = -1;
      for (int i = 0; i < V; i++) if (m_note[i] == 0 && t < 0) t = i;
      if (t < 0) begin
        t = lru[$];
        m_steal = 1'b1;
      end
      m_note[t] = k;
      m_oct[t]  = m_octave;
      for (int j = 0; j < lru.size(); j++) begin
        if (lru[j] == t) begin
          lru.delete(j);
          break;
        end
      end
      lru.push_front(t);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit o);
    int k;
    m_steal = 1'b0;
    if (o) begin
      for (int i = 0; i < V; i++) m_note[i] = 0;
      m_pend_brk = 1'b0;
      m_pend_ext = 1'b0;
    end else if (v) begin
      if (m_pend_ext) begin
        if (b == 8'hF0 && !m_pend_brk) m_pend_brk = 1'b1;
        else begin
          m_pend_brk = 1'b0;
          m_pend_ext = 1'b0;
        end
      end else if (m_pend_brk) begin
        m_pend_brk = 1'b0;
        k = keymap(b);
        if (k >= 1 && k <= 7)
          for (int i = 0; i < V; i++) if (m_note[i] == k) m_note[i] = 0;
      end else if (b == 8'hF0) m_pend_brk = 1'b1;
      else if (b == 8'hE0)     m_pend_ext = 1'b1;
      else                     model_make(b);
    end
  endtask

  // One clock of stimulus; returns just after the edge that consumed it.
  task automatic cyc(input bit v, input logic [7:0] b, input bit o);
    @(negedge sys_clk);
    #1;
    ps2_valid = v;
    ps2_byte  = b;
    ps2_ovf   = o;
    model_step(v, b, o);
    @(posedge sys_clk);
    #1;
    ps2_valid = 1'b0;
    ps2_ovf   = 1'b0;
  endtask

  task automatic key(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_notes", 32'(notes), 32'd0);
    chk("rst_octave", 32'(octave), 32'(OI));
    @(negedge sys_clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      e_act = 4'd0;
      for (int i = 0; i < V; i++) begin
        e_notes[4*i +: 4] = m_note[i][3:0];
        e_octs[2*i +: 2]  = m_oct[i][1:0];
        if (m_note[i] != 0) e_act = e_act + 4'd1;
      end
      chk("notes", 32'(notes), 32'(e_notes));
      chk("octs", 32'(octs), 32'(e_octs));
      chk("octave", 32'(octave), 32'(m_octave));
      chk("active", 32'(active), 32'(e_act));
      chk("steal", 32'(steal), 32'(m_steal));
    end
  end

  logic [7:0] pick_tbl [12];

  initial begin
    rst_n     = 1'b0;
    ps2_byte  = 8'h00;
    ps2_valid = 1'b0;
    ps2_ovf   = 1'b0;
    model_reset();
    chk_en    = 1'b1;
    #22;
    chk("init_octs", 32'(octs), 32'd0);
    chk("init_steal", 32'(steal), 32'd0);
    rst_n = 1'b1;

    // Two makes land in voices 0 and 1 at the current octave.
    key(8'h1C);
    chk("m1_notes", 32'(notes), 32'h0001);
    key(8'h1B);
    chk("m2_notes", 32'(notes), 32'h0021);
    chk("m2_octs", 32'(octs), 32'h05);
    chk("m2_active", 32'(active), 32'd2);

    do_reset();
    key(8'h1C);
    key(8'h1C);
    chk("rep_active", 32'(active), 32'd1);
    key(8'hF0);
    key(8'h1C);
    chk("brk_notes", 32'(notes), 32'h0000);
    chk("brk_active", 32'(active), 32'd0);

    do_reset();
    key(8'h1C); key(8'h1B); key(8'h23); key(8'h2B);
    key(8'h34);
    chk("steal_notes", 32'(notes), 32'h4325);
    chk("steal_pulse", 32'(steal), 32'd1);
    chk("steal_active", 32'(active), 32'd4);
    cyc(1'b0, 8'h00, 1'b0);
    chk("steal_drop", 32'(steal), 32'd0);

    do_reset();
    key(8'h22); chk("oct_a", 32'(octave), 32'd2);
    key(8'h22); chk("oct_b", 32'(octave), 32'd3);
    key(8'h22); chk("oct_c", 32'(octave), 32'd3);
    key(8'h22); chk("oct_d", 32'(octave), 32'd3);
    key(8'h1C); chk("oct_v0", 32'(octs), 32'h03);
    key(8'h1A);
    chk("oct_dn", 32'(octave), 32'd2);
    chk("oct_keep", 32'(octs), 32'h03);

    do_reset();
    key(8'hE0); key(8'h1C); key(8'hE0); key(8'hF0); key(8'h1C);
    chk("ext_notes", 32'(notes), 32'h0000);
    key(8'h1C);
    chk("ext_resync", 32'(notes), 32'h0001);

    do_reset();
    key(8'h1C); key(8'h1B);
    cyc(1'b1, 8'h23, 1'b1);
    chk("ovf_notes", 32'(notes), 32'h0000);
    chk("ovf_active", 32'(active), 32'd0);
    chk("ovf_octave", 32'(octave), 32'd1);

    do_reset();
    key(8'hF0);
    do_reset();
    key(8'h1C);
    chk("rst_prefix", 32'(notes), 32'h0001);

    pick_tbl = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
                 8'h3B, 8'h1A, 8'h22, 8'hF0, 8'hF0, 8'hE0};
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      int         r;
      if ($urandom_range(0, 399) == 0) do_reset();
      r = int'($urandom_range(0, 13));
      b = (r < 12) ? pick_tbl[r] : 8'($urandom);
      cyc(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 59) == 0));
    end

    @(negedge sys_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 4, meaning number of simultaneous voices (legal range 2..8).
REQ-002 SHALL have parameter OCT_INIT, default 1, meaning octave value loaded at reset (legal range 0..3).
REQ-003 SHALL have port sys_clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_byte  input  8  PS/2 set-2 scan-code byte from the decoder.
REQ-006 SHALL have port ps2_valid  input  1  one-cycle strobe qualifying ps2_byte.
REQ-007 SHALL have port ps2_ovf  input  1  decoder overflow flag, level-sensitive.
REQ-008 SHALL have port notes  output  4*VOICES  per-voice note; voice i at [4i+3:4i]; 0 = silent, 1..7 = do..ti.
REQ-009 SHALL have port octs  output  2*VOICES  per-voice octave; voice i at [2i+1:2i].
REQ-010 SHALL have port octave  output  2  current global octave.
REQ-011 SHALL have port active  output  4  count of non-silent voices.
REQ-012 SHALL have port steal  output  1  one-cycle pulse when a sounding voice is reassigned.

Function
REQ-013 Key map SHALL be: 0x1C->1, 0x1B->2, 0x23->3, 0x2B->4, 0x34->5, 0x33->6, 0x3B->7; 0x1A = octave down; 0x22 = octave up; all other codes unmapped.
REQ-014 Parser SHALL be an FSM with states IDLE, BRK, EXT, EXT_BRK, advancing only on cycles with ps2_valid=1.
REQ-015 IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte = make of that code, stay IDLE.
REQ-016 BRK: any byte = break of that code -> IDLE.
REQ-017 EXT: 0xF0 -> EXT_BRK; any other byte discarded -> IDLE. EXT_BRK: byte discarded -> IDLE (extended keys ignored).
REQ-018 Each voice SHALL store a note (4 b), an octave (2 b) and an LRU rank (0 = newest).
REQ-019 Make of mapped note already held by any voice (typematic repeat) SHALL change nothing.
REQ-020 Make of new mapped note SHALL load the lowest-index silent voice with note and current octave.
REQ-021 If no voice is silent, the voice with highest rank (oldest) SHALL be reloaded, with steal=1 for one cycle.
REQ-022 On allocation, target rank := 0; every voice with rank below the target's old rank increments; others unchanged; ranks remain a permutation of 0..VOICES-1.
REQ-023 Break of a mapped note SHALL clear to 0 the voice holding it; break of a note not held SHALL be ignored.
REQ-024 Octave-up make SHALL increment octave saturating at 3; octave-down make SHALL decrement saturating at 0; repeats step again; breaks ignored.
REQ-025 Octave change SHALL NOT alter octs of already-sounding voices.
REQ-026 Unmapped makes/breaks SHALL change no output.
REQ-027 All outputs SHALL be registered; effects of a byte strobed in cycle N SHALL be visible in cycle N+1.
REQ-028 active SHALL equal the number of voices with note != 0, registered alongside notes.
REQ-029 ps2_ovf=1 SHALL, in the same clock edge, force parser to IDLE, all notes to 0, and ignore ps2_valid; octave and ranks SHALL be retained.
REQ-030 ps2_ovf has priority over ps2_valid when both are asserted in the same cycle.

Reset
REQ-031 rst_n=0 SHALL asynchronously set notes=0, octs=0, octave=OCT_INIT, active=0, steal=0, parser IDLE, and voice i rank := i.
REQ-032 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; the first byte after release is parsed from IDLE.

Verification
REQ-033 Bytes 1C, 1B -> cycle after each: voice0=1, then voice1=2; octs both 1; active=2.
REQ-034 1C, 1C, F0 1C -> repeat leaves active=1; after break voice0=0, active=0.
REQ-035 VOICES=4: makes 1C,1B,23,2B,34 -> fifth make overwrites voice0 (oldest) with 5, steal pulses one cycle, active=4.
REQ-036 22,22,22,22 from reset -> octave 2,3,3,3; then 1C -> voice0 octs=3; then 1A -> octave=2, voice0 octs stays 3.
REQ-037 E0 1C, E0 F0 1C -> no output change; then 1C -> voice0=1 (parser resynchronised).
REQ-038 Two voices held, ps2_ovf=1 with ps2_valid=1 byte 23 -> next cycle all notes 0, active=0, octave unchanged, byte 23 not allocated.
